// File: rtl/image_stream_proc.sv
// ---------------------------------------------------------------------------
// image_stream_proc
//
// Streams one frame out of a word-addressed pixel memory.
// - Rows are read bottom-up.
// - Each beat of PPC pixels goes through a per-pixel point operation
//   (brightness, invert, threshold or pass-through).
// - Results are queued in a 2-entry ready/valid output FIFO.
// - A start-up VSYNC phase precedes the frame, and an HSYNC blanking phase
//   precedes every line.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   start                frame request pulse (honoured only when idle)
//   mode, value,
//   threshold            operation select and its operands, latched on start
//   mem_rd, mem_addr     memory read strobe and word address
//   mem_rdata            read data, valid one cycle after mem_rd
//   out_valid/out_ready  output handshake
//   out_data             processed pixels, pixel k in bits [24k+23:24k]
//   out_sof, out_eol     first beat of frame / last beat of line markers
//   VSYNC, HSYNC         start-up and line blanking phases
//   busy, ctrl_done      frame in progress / frame complete pulse
// ---------------------------------------------------------------------------
module image_stream_proc #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int PPC            = 2,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int ADDR_W         = 20
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [7:0]        value,
  input  logic [7:0]        threshold,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [24*PPC-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [24*PPC-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              busy,
  output logic              ctrl_done
);

  localparam int DW      = 24 * PPC;
  localparam int BEATS   = WIDTH / PPC;
  localparam int COL_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_HSYNC,
    ST_DATA,
    ST_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DLY_W-1:0]  r_dly;
  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic [2:0]        r_mode;
  logic [7:0]        r_value;
  logic [7:0]        r_thr;
  logic              r_rdPend;
  logic              r_pendSof;
  logic              r_pendEol;

  logic [DW-1:0]     r_fifoData [2];
  logic [1:0]        r_fifoSof;
  logic [1:0]        r_fifoEol;
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [1:0]        r_fifoCnt;

  logic              w_accept;
  logic              w_rd;
  logic              w_done;
  logic              w_pop;
  logic              w_credit;
  logic [2:0]        w_occ;
  logic              w_lastCol;
  logic              w_lastLine;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_addr;
  logic [DW-1:0]     w_procData;

  // Saturating 8-bit channel arithmetic.
  function automatic logic [7:0] satAdd(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] satSub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  // Point operation on one RGB pixel. Gray is floor((R+G+B)/3) from a 10-bit
  // sum; the maximum 765/3 = 255 always fits back into 8 bits.
  function automatic logic [23:0] procPixel(input logic [23:0] px, input logic [2:0] m,
                                            input logic [7:0] v, input logic [7:0] t);
    logic [9:0]  sum;
    logic [7:0]  gray;
    logic [23:0] res;
    sum  = 10'(px[23:16]) + 10'(px[15:8]) + 10'(px[7:0]);
    gray = 8'(sum / 10'd3);
    case (m)
      3'd1:    res = {satAdd(px[23:16], v), satAdd(px[15:8], v), satAdd(px[7:0], v)};
      3'd2:    res = {satSub(px[23:16], v), satSub(px[15:8], v), satSub(px[7:0], v)};
      3'd3:    res = {3{8'd255 - gray}};
      3'd4:    res = (gray > t) ? 24'hFF_FFFF : 24'h00_0000;
      default: res = px;
    endcase
    return res;
  endfunction

  assign w_lastCol  = (r_col == COL_W'(BEATS - 1));
  assign w_lastLine = (r_line == LINE_W'(HEIGHT - 1));
  assign w_accept   = (r_state == ST_IDLE) && start;

  // Bottom-up storage: output line r comes from memory row HEIGHT-1-r.
  assign w_row  = ADDR_W'(HEIGHT - 1) - ADDR_W'(r_line);
  assign w_addr = (w_row * ADDR_W'(BEATS)) + ADDR_W'(r_col);

  assign out_valid = (r_fifoCnt != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // Credit: a beat in flight or in the FIFO holds one of the two slots; a
  // beat leaving this cycle frees its slot, which keeps one read per cycle.
  assign w_occ    = 3'(r_fifoCnt) + 3'(r_rdPend) - 3'(w_pop);
  assign w_credit = (w_occ < 3'd2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_VSYNC;
        end
      end
      ST_VSYNC: begin
        if (r_dly == DLY_W'(START_UP_DELAY - 1)) begin
          w_next = ST_HSYNC;
        end
      end
      ST_HSYNC: begin
        if (r_dly == DLY_W'(HSYNC_DELAY - 1)) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_credit) begin
          w_rd = 1'b1;
          if (w_lastCol) begin
            w_next = w_lastLine ? ST_DRAIN : ST_HSYNC;
          end
        end
      end
      ST_DRAIN: begin
        // Last read returned and its beat has been taken by the sink.
        if ((r_fifoCnt == 2'd0) && !r_rdPend) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Phase delay counter restarts on every state change.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dly <= '0;
    end else if ((w_next != r_state) || !((r_state == ST_VSYNC) || (r_state == ST_HSYNC))) begin
      r_dly <= '0;
    end else begin
      r_dly <= r_dly + 1'b1;
    end
  end

  // Beat/line position, frame parameters latched at start, and the tags that
  // travel with each read until its data returns.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_col     <= '0;
      r_line    <= '0;
      r_mode    <= '0;
      r_value   <= '0;
      r_thr     <= '0;
      r_rdPend  <= 1'b0;
      r_pendSof <= 1'b0;
      r_pendEol <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col   <= '0;
        r_line  <= '0;
        r_mode  <= mode;
        r_value <= value;
        r_thr   <= threshold;
      end else if (w_rd) begin
        if (w_lastCol) begin
          r_col  <= '0;
          r_line <= w_lastLine ? '0 : (r_line + 1'b1);
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      r_rdPend  <= w_rd;
      r_pendSof <= w_rd && (r_col == '0) && (r_line == '0);
      r_pendEol <= w_rd && w_lastCol;
    end
  end

  always_comb begin
    w_procData = '0;
    for (int k = 0; k < PPC; k++) begin
      w_procData[24*k +: 24] = procPixel(mem_rdata[24*k +: 24], r_mode, r_value, r_thr);
    end
  end

  // Output FIFO. The credit check guarantees a push never finds it full.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_fifoData[0] <= '0;
      r_fifoData[1] <= '0;
      r_fifoSof     <= '0;
      r_fifoEol     <= '0;
      r_wrPtr       <= 1'b0;
      r_rdPtr       <= 1'b0;
      r_fifoCnt     <= '0;
    end else begin
      if (r_rdPend) begin
        r_fifoData[r_wrPtr] <= w_procData;
        r_fifoSof[r_wrPtr]  <= r_pendSof;
        r_fifoEol[r_wrPtr]  <= r_pendEol;
        r_wrPtr             <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_fifoCnt <= r_fifoCnt + 2'(r_rdPend) - 2'(w_pop);
    end
  end

  assign mem_rd    = w_rd;
  assign mem_addr  = w_rd ? w_addr : '0;
  assign out_data  = out_valid ? r_fifoData[r_rdPtr] : '0;
  assign out_sof   = out_valid && r_fifoSof[r_rdPtr];
  assign out_eol   = out_valid && r_fifoEol[r_rdPtr];
  assign VSYNC     = (r_state == ST_VSYNC);
  assign HSYNC     = (r_state == ST_HSYNC);
  assign busy      = (r_state != ST_IDLE);
  assign ctrl_done = w_done;

endmodule
